acc_bank: RTL and testbench

Parametrised multi-channel signed accumulator for the tp3 datapath: the next generation of the single 16-bit `acc` register. It holds CHANNELS independent WIDTH-bit accumulators. Each accepted operation (load, add, subtract, clear, read) acts on one selected channel. The updated value is presented on a registered output with status flags (zero, negative, sticky overflow) and a one-cycle valid strobe. Wrap-around or saturating arithmetic is selected at elaboration time.

---
 rtl/acc_bank.sv | 137 +++++++++++++
 tb/tb_acc_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/acc_bank.sv
// Multi-channel signed accumulator bank: one op per cycle on a selected channel,
// registered result with zero/negative/sticky-overflow flags and a valid strobe.
module acc_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       op,
    input  logic [CH_W-1:0]  ch,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic [CH_W-1:0]  out_ch,
    output logic             out_valid,
    output logic             zero,
    output logic             negative,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_READ = 3'b101;

    localparam logic [CH_W:0]  CH_LIMIT = CHANNELS[CH_W:0];
    localparam logic [MSB:0]   MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [MSB:0]   MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [MSB:0]          r_acc [CHANNELS];
    logic [CHANNELS-1:0]   r_ovf_ch;

    logic [MSB:0]          r_out_data;
    logic [CH_W-1:0]       r_out_ch;
    logic                  r_out_valid;
    logic                  r_zero;
    logic                  r_negative;
    logic                  r_out_ovf;

    logic                  w_op_valid;
    logic                  w_ch_ok;
    logic                  w_accept;
    logic [MSB:0]          w_cur;
    logic                  w_cur_ovf;
    logic [MSB:0]          w_sum;
    logic [MSB:0]          w_dif;
    logic                  w_add_ovf;
    logic                  w_sub_ovf;
    logic [MSB:0]          w_sat;
    logic [MSB:0]          w_new_acc;
    logic                  w_new_ovf;

    assign w_ch_ok  = ({1'b0, ch} < CH_LIMIT);
    assign w_accept = enable & w_op_valid & w_ch_ok;

    always_comb begin
        w_op_valid = 1'b0;
        case (op)
            OP_LOAD, OP_ADD, OP_SUB, OP_CLR, OP_READ: w_op_valid = 1'b1;
            default:                                  w_op_valid = 1'b0;
        endcase
    end

    // Overflow direction always follows the accumulator's sign, for both ADD and SUB.
    always_comb begin
        w_cur     = r_acc[ch];
        w_cur_ovf = r_ovf_ch[ch];
        w_sum     = w_cur + in_data;
        w_dif     = w_cur - in_data;
        w_add_ovf = (w_cur[MSB] == in_data[MSB]) && (w_sum[MSB] != w_cur[MSB]);
        w_sub_ovf = (w_cur[MSB] != in_data[MSB]) && (w_dif[MSB] != w_cur[MSB]);
        w_sat     = w_cur[MSB] ? MIN_NEG : MAX_POS;
        w_new_acc = w_cur;
        w_new_ovf = w_cur_ovf;
        case (op)
            OP_LOAD: begin
                w_new_acc = in_data;
                w_new_ovf = 1'b0;
            end
            OP_ADD: begin
                w_new_acc = ((SATURATE != 0) && w_add_ovf) ? w_sat : w_sum;
                w_new_ovf = w_cur_ovf | w_add_ovf;
            end
            OP_SUB: begin
                w_new_acc = ((SATURATE != 0) && w_sub_ovf) ? w_sat : w_dif;
                w_new_ovf = w_cur_ovf | w_sub_ovf;
            end
            OP_CLR: begin
                w_new_acc = '0;
                w_new_ovf = 1'b0;
            end
            default: begin
                w_new_acc = w_cur;
                w_new_ovf = w_cur_ovf;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
            r_ovf_ch    <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b1;
            r_negative  <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_acc[ch]    <= w_new_acc;
                r_ovf_ch[ch] <= w_new_ovf;
                r_out_data   <= w_new_acc;
                r_out_ch     <= ch;
                r_out_ovf    <= w_new_ovf;
                r_zero       <= (w_new_acc == '0);
                r_negative   <= w_new_acc[MSB];
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign ovf       = r_out_ovf;

endmodule

// File: tb/tb_acc_bank.sv
// Directed bench for acc_bank: three instances (wrap/4ch, saturate/4ch, wrap/3ch)
// driven from one vector table plus a back-to-back saturation sequence.
module tb_acc_bank;

    localparam logic [2:0] NOP = 3'd0, LD = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           CLR = 3'd4, RD = 3'd5, RSV = 3'd7;

    logic        clk = 1'b0;
    logic        rst_v  [3];
    logic        en_v   [3];
    logic [2:0]  op_v   [3];
    logic [1:0]  ch_v   [3];
    logic [15:0] din_v  [3];
    logic [15:0] od     [3];
    logic [1:0]  och    [3];
    logic        ov     [3];
    logic        oz     [3];
    logic        on     [3];
    logic        oo     [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    acc_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst_v[0]), .enable(en_v[0]), .op(op_v[0]), .ch(ch_v[0]),
        .in_data(din_v[0]), .out_data(od[0]), .out_ch(och[0]), .out_valid(ov[0]),
        .zero(oz[0]), .negative(on[0]), .ovf(oo[0]));

    acc_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst_v[1]), .enable(en_v[1]), .op(op_v[1]), .ch(ch_v[1]),
        .in_data(din_v[1]), .out_data(od[1]), .out_ch(och[1]), .out_valid(ov[1]),
        .zero(oz[1]), .negative(on[1]), .ovf(oo[1]));

    acc_bank #(.WIDTH(16), .CHANNELS(3), .SATURATE(0)) u_ch3 (
        .clk(clk), .rst(rst_v[2]), .enable(en_v[2]), .op(op_v[2]), .ch(ch_v[2]),
        .in_data(din_v[2]), .out_data(od[2]), .out_ch(och[2]), .out_valid(ov[2]),
        .zero(oz[2]), .negative(on[2]), .ovf(oo[2]));

    typedef struct {
        int          dut;
        logic        rst;
        logic        en;
        logic [2:0]  op;
        logic [1:0]  ch;
        logic [15:0] din;
        logic [15:0] e_data;
        logic [1:0]  e_ch;
        logic        e_v;
        logic        e_z;
        logic        e_n;
        logic        e_o;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input int d, input logic r, input logic e, input logic [2:0] o,
                           input logic [1:0] c, input logic [15:0] di, input logic [15:0] ed,
                           input logic [1:0] ec, input logic evl, input logic ez,
                           input logic en_, input logic eo);
        vec_t v;
        v.dut = d; v.rst = r; v.en = e; v.op = o; v.ch = c; v.din = di;
        v.e_data = ed; v.e_ch = ec; v.e_v = evl; v.e_z = ez; v.e_n = en_; v.e_o = eo;
        tbl.push_back(v);
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b0; en_v[i] = 1'b0; op_v[i] = NOP; ch_v[i] = 2'd0; din_v[i] = 16'h0;
        end
    endtask

    task automatic drive(input int d, input logic r, input logic e, input logic [2:0] o,
                         input logic [1:0] c, input logic [15:0] di);
        idle_all();
        rst_v[d] = r; en_v[d] = e; op_v[d] = o; ch_v[d] = c; din_v[d] = di;
        @(posedge clk);
        #1;
        idle_all();
    endtask

    task automatic chk(input string tag, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", tag, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input int d, input logic [15:0] ed,
                           input logic [1:0] ec, input logic evl, input logic ez,
                           input logic en_, input logic eo);
        chk("out_data",  idx, od[d], ed);
        chk("out_ch",    idx, {14'h0, och[d]}, {14'h0, ec});
        chk("out_valid", idx, {15'h0, ov[d]},  {15'h0, evl});
        chk("zero",      idx, {15'h0, oz[d]},  {15'h0, ez});
        chk("negative",  idx, {15'h0, on[d]},  {15'h0, en_});
        chk("ovf",       idx, {15'h0, oo[d]},  {15'h0, eo});
    endtask

    initial begin
        int   model;
        logic mo;
        idle_all();

        // dut, rst, en, op, ch, din, exp data, ch, valid, zero, neg, ovf
        add_vec(0, 1, 0, NOP, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
        add_vec(1, 1, 0, NOP, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
        add_vec(2, 1, 0, NOP, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
        // basic + ignored ops on the wrap instance
        add_vec(0, 0, 1, LD,  0, 16'h0003, 16'h0003, 0, 1, 0, 0, 0);
        add_vec(0, 0, 1, ADD, 0, 16'h0007, 16'h000A, 0, 1, 0, 0, 0);
        add_vec(0, 0, 0, NOP, 0, 16'h0000, 16'h000A, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0, ADD, 0, 16'h0005, 16'h000A, 0, 0, 0, 0, 0);
        add_vec(0, 0, 1, RSV, 0, 16'h0001, 16'h000A, 0, 0, 0, 0, 0);
        add_vec(0, 0, 1, RD,  0, 16'h0000, 16'h000A, 0, 1, 0, 0, 0);
        // wrap-around overflow, sticky across READ and further ADD
        add_vec(0, 0, 1, LD,  0, 16'h7FFF, 16'h7FFF, 0, 1, 0, 0, 0);
        add_vec(0, 0, 1, ADD, 0, 16'h0001, 16'h8000, 0, 1, 0, 1, 1);
        add_vec(0, 0, 1, RD,  0, 16'h0000, 16'h8000, 0, 1, 0, 1, 1);
        add_vec(0, 0, 1, ADD, 0, 16'h8000, 16'h0000, 0, 1, 1, 0, 1);
        add_vec(0, 0, 1, CLR, 0, 16'h1234, 16'h0000, 0, 1, 1, 0, 0);
        // channel isolation
        add_vec(0, 0, 1, LD,  1, 16'h0005, 16'h0005, 1, 1, 0, 0, 0);
        add_vec(0, 0, 1, LD,  2, 16'h0009, 16'h0009, 2, 1, 0, 0, 0);
        add_vec(0, 0, 1, ADD, 1, 16'h0001, 16'h0006, 1, 1, 0, 0, 0);
        add_vec(0, 0, 1, RD,  2, 16'h0000, 16'h0009, 2, 1, 0, 0, 0);
        add_vec(0, 0, 1, SUB, 3, 16'h8000, 16'h8000, 3, 1, 0, 1, 1);
        add_vec(0, 0, 1, RD,  0, 16'h0000, 16'h0000, 0, 1, 1, 0, 0);
        add_vec(0, 0, 1, LD,  1, 16'h0002, 16'h0002, 1, 1, 0, 0, 0);
        add_vec(0, 0, 1, SUB, 1, 16'h0005, 16'hFFFD, 1, 1, 0, 1, 0);
        // reset wins over an accepted op, and clears every channel
        add_vec(0, 1, 1, ADD, 1, 16'h0002, 16'h0000, 0, 0, 1, 0, 0);
        add_vec(0, 0, 1, RD,  1, 16'h0000, 16'h0000, 1, 1, 1, 0, 0);
        add_vec(0, 0, 1, RD,  2, 16'h0000, 16'h0000, 2, 1, 1, 0, 0);
        add_vec(0, 0, 1, RD,  3, 16'h0000, 16'h0000, 3, 1, 1, 0, 0);
        // saturating instance
        add_vec(1, 0, 1, LD,  0, 16'h8000, 16'h8000, 0, 1, 0, 1, 0);
        add_vec(1, 0, 1, SUB, 0, 16'h0001, 16'h8000, 0, 1, 0, 1, 1);
        add_vec(1, 0, 1, LD,  0, 16'h7FFE, 16'h7FFE, 0, 1, 0, 0, 0);
        add_vec(1, 0, 1, ADD, 0, 16'h0005, 16'h7FFF, 0, 1, 0, 0, 1);
        add_vec(1, 0, 1, ADD, 0, 16'h0001, 16'h7FFF, 0, 1, 0, 0, 1);
        add_vec(1, 0, 1, LD,  0, 16'h0004, 16'h0004, 0, 1, 0, 0, 0);
        add_vec(1, 0, 1, SUB, 0, 16'hFFFF, 16'h0005, 0, 1, 0, 0, 0);
        add_vec(1, 0, 1, LD,  2, 16'h8001, 16'h8001, 2, 1, 0, 1, 0);
        add_vec(1, 0, 1, ADD, 2, 16'hFFFF, 16'h8000, 2, 1, 0, 1, 0);
        add_vec(1, 0, 1, SUB, 2, 16'h7FFF, 16'h8000, 2, 1, 0, 1, 1);
        // three-channel instance: ch=3 is out of range
        add_vec(2, 0, 1, LD,  2, 16'h0011, 16'h0011, 2, 1, 0, 0, 0);
        add_vec(2, 0, 1, LD,  3, 16'h0008, 16'h0011, 2, 0, 0, 0, 0);
        add_vec(2, 0, 1, RD,  3, 16'h0000, 16'h0011, 2, 0, 0, 0, 0);
        add_vec(2, 0, 1, RD,  2, 16'h0000, 16'h0011, 2, 1, 0, 0, 0);
        add_vec(2, 0, 1, RD,  0, 16'h0000, 16'h0000, 0, 1, 1, 0, 0);

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].dut, tbl[i].rst, tbl[i].en, tbl[i].op, tbl[i].ch, tbl[i].din);
            chk_all(i, tbl[i].dut, tbl[i].e_data, tbl[i].e_ch, tbl[i].e_v,
                    tbl[i].e_z, tbl[i].e_n, tbl[i].e_o);
        end

        // back-to-back accumulation into positive saturation on ch3
        model = 32'sh7FF0;
        mo    = 1'b0;
        idle_all();
        rst_v[1] = 1'b0; en_v[1] = 1'b1; op_v[1] = LD; ch_v[1] = 2'd3; din_v[1] = 16'h7FF0;
        @(posedge clk);
        #1;
        chk_all(1000, 1, model[15:0], 2'd3, 1'b1, 1'b0, 1'b0, mo);
        for (int k = 0; k < 6; k++) begin
            op_v[1]  = ADD;
            din_v[1] = 16'h0004;
            @(posedge clk);
            #1;
            model = model + 4;
            if (model > 32767) begin
                model = 32767;
                mo    = 1'b1;
            end
            chk_all(1001 + k, 1, model[15:0], 2'd3, 1'b1, 1'b0, 1'b0, mo);
        end
        idle_all();
        @(posedge clk);
        #1;
        chk("valid_drop", 1007, {15'h0, ov[1]}, 16'h0000);
        chk("hold_data",  1007, od[1], 16'h7FFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
